// File: rtl/pf_lanectrl_pause_sync_mc.sv
// Multi-lane pause synchroniser: per-lane async request sync, minimum-width pulse stretcher, optional falling-edge output.
// Optional stretch-event counter enabled by defining LANECTRL_PAUSE_STRETCH_CNT_EN.
module pf_lanectrl_pause_sync_mc #(
    parameter int NUM_LANES        = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PAUSE_CYCLES = 2,
    parameter int FALL_OUTPUT      = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    input  logic [NUM_LANES-1:0] PAUSE_MASK,
`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
    input  logic                 STRETCH_CNT_CLR,
    output logic [7:0]           STRETCH_CNT,
`endif
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
    output logic                 PAUSE_ACTIVE
);

    typedef enum logic [1:0] {IDLE, HOLD, TRACK} lane_state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MIN_PAUSE_CYCLES - 1);

    logic [NUM_LANES-1:0] active_d;
    logic [NUM_LANES-1:0] hold_exit;
    logic [NUM_LANES-1:0] sync_q;
    logic                 active_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [SYNC_STAGES-1:0] chain_q;
        lane_state_t            state_q, state_d;
        logic [3:0]             cnt_q, cnt_d;
        logic                   sync_bit;

        assign sync_bit = chain_q[SYNC_STAGES-1];

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                chain_q <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                chain_q <= {chain_q[SYNC_STAGES-2:0], HS_IO_CLK_PAUSE[g]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // NOTE: defaults assigned first so no path through the case leaves a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                IDLE: begin
                    if (sync_bit && !PAUSE_MASK[g]) begin
                        state_d = HOLD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (sync_bit) begin
                        state_d = TRACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                TRACK: begin
                    if (!sync_bit) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Output flop is loaded from next-state so it stays aligned with the state register.
        assign active_d[g]  = (state_d != IDLE);
        assign hold_exit[g] = (state_q == HOLD) && (state_d == IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q   <= '0;
            active_q <= 1'b0;
        end else begin
            sync_q   <= active_d;
            active_q <= |active_d;
        end
    end

    if (FALL_OUTPUT != 0) begin : g_fall
        logic [NUM_LANES-1:0] sync_f;
        logic                 active_f;

        always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) begin
                sync_f   <= '0;
                active_f <= 1'b0;
            end else begin
                sync_f   <= sync_q;
                active_f <= active_q;
            end
        end

        assign HS_IO_CLK_PAUSE_SYNC = sync_f;
        assign PAUSE_ACTIVE         = active_f;
    end else begin : g_rise
        assign HS_IO_CLK_PAUSE_SYNC = sync_q;
        assign PAUSE_ACTIVE         = active_q;
    end

`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
    // Counts cycles where some pulse ended purely on its minimum width.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STRETCH_CNT <= 8'd0;
        end else if (STRETCH_CNT_CLR) begin
            STRETCH_CNT <= 8'd0;
        end else if ((|hold_exit) && (STRETCH_CNT != 8'hFF)) begin
            STRETCH_CNT <= STRETCH_CNT + 8'd1;
        end
    end
`else
    logic unused_hold_exit;
    assign unused_hold_exit = |hold_exit;
`endif

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_mc.sv
// Self-checking bench: three configurations against a pulse-level behavioural model plus literal pins.
`timescale 1ns/1ps
module tb_pf_lanectrl_pause_sync_mc;
    localparam int NL = 4;
    localparam int ND = 3;

    logic CLK = 1'b0;
    logic RESET;
    logic [NL-1:0] req, mask;
    logic [NL-1:0] sync_o [ND];
    logic          act_o  [ND];
    logic          clr;
    logic [7:0]    scnt   [ND];

    int n_checks = 0;
    int n_errors = 0;

    initial forever #5 CLK = ~CLK;

`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(2), .FALL_OUTPUT(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .STRETCH_CNT_CLR(clr), .STRETCH_CNT(scnt[0]),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[0]), .PAUSE_ACTIVE(act_o[0]));
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(3), .MIN_PAUSE_CYCLES(2), .FALL_OUTPUT(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .STRETCH_CNT_CLR(clr), .STRETCH_CNT(scnt[1]),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[1]), .PAUSE_ACTIVE(act_o[1]));
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(4), .FALL_OUTPUT(0)) dut_c (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .STRETCH_CNT_CLR(clr), .STRETCH_CNT(scnt[2]),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[2]), .PAUSE_ACTIVE(act_o[2]));
`else
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(2), .FALL_OUTPUT(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[0]), .PAUSE_ACTIVE(act_o[0]));
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(3), .MIN_PAUSE_CYCLES(2), .FALL_OUTPUT(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[1]), .PAUSE_ACTIVE(act_o[1]));
    pf_lanectrl_pause_sync_mc #(.NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PAUSE_CYCLES(4), .FALL_OUTPUT(0)) dut_c (
        .CLK(CLK), .RESET(RESET), .HS_IO_CLK_PAUSE(req), .PAUSE_MASK(mask),
        .HS_IO_CLK_PAUSE_SYNC(sync_o[2]), .PAUSE_ACTIVE(act_o[2]));
    assign scnt[0] = 8'd0;
    assign scnt[1] = 8'd0;
    assign scnt[2] = 8'd0;
`endif

    function automatic int s_of(int d);
        return (d == 1) ? 3 : 2;
    endfunction
    function automatic int m_of(int d);
        return (d == 2) ? 4 : 2;
    endfunction

    // Model: a pulse opens on an unmasked synchronised request, lasts at least m_of() edges,
    // then persists while the delayed request stays high.
    logic [3:0] hist [ND][NL];
    bit         on   [ND][NL];
    int         age  [ND][NL];
    int         m_cnt[ND];

    logic [NL-1:0] snap_pos [ND];
    logic [NL-1:0] snap_neg [ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            m_cnt[d] = 0;
            for (int l = 0; l < NL; l++) begin
                hist[d][l] = '0;
                on[d][l]   = 1'b0;
                age[d][l]  = 0;
            end
        end
    endtask

    task automatic model_edge(input int d);
        bit any_exit;
        bit x;
        any_exit = 1'b0;
        for (int l = 0; l < NL; l++) begin
            x = hist[d][l][s_of(d)-1];
            hist[d][l] = {hist[d][l][2:0], req[l]};
            if (!on[d][l]) begin
                if (x && !mask[l]) begin
                    on[d][l]  = 1'b1;
                    age[d][l] = 0;
                end
            end else begin
                age[d][l]++;
                if (age[d][l] >= m_of(d) && !x) begin
                    if (age[d][l] == m_of(d)) any_exit = 1'b1;
                    on[d][l] = 1'b0;
                end
            end
        end
`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
        if (clr) m_cnt[d] = 0;
        else if (any_exit && m_cnt[d] < 255) m_cnt[d]++;
`endif
    endtask

    function automatic logic [NL-1:0] exp_vec(input int d);
        logic [NL-1:0] v;
        for (int l = 0; l < NL; l++) v[l] = on[d][l];
        return v;
    endfunction

    task automatic compare(input int d);
        check($sformatf("sync_d%0d", d), 32'(sync_o[d]), 32'(exp_vec(d)));
        check($sformatf("active_d%0d", d), 32'(act_o[d]), 32'(|exp_vec(d)));
    endtask

    // One clock: model update on the rising edge, compare rising-edge outputs just after it,
    // falling-edge outputs just after the falling edge.
    task automatic step();
        @(posedge CLK);
        if (RESET) model_clear();
        else for (int d = 0; d < ND; d++) model_edge(d);
        #1;
        compare(0);
        compare(2);
`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
        for (int d = 0; d < ND; d++) check($sformatf("scnt_d%0d", d), 32'(scnt[d]), 32'(m_cnt[d]));
`endif
        for (int d = 0; d < ND; d++) snap_pos[d] = sync_o[d];
        @(negedge CLK);
        #1;
        compare(1);
        for (int d = 0; d < ND; d++) snap_neg[d] = sync_o[d];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int cnt_a, cnt_b, cnt_c;
    int ea [8];
    int eb [8];
    int ec [8];

    initial begin
        RESET = 1'b1; req = '0; mask = '0; clr = 1'b0;
        model_clear();
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_sync_d%0d", d), 32'(sync_o[d]), 32'h0);
            check($sformatf("reset_act_d%0d", d), 32'(act_o[d]), 32'h0);
            check($sformatf("reset_scnt_d%0d", d), 32'(scnt[d]), 32'h0);
        end
        idle(2);
        RESET = 1'b0;
        idle(2);

        // Single-cycle request on lane 0.
        ea = '{0, 0, 1, 1, 0, 0, 0, 0};
        eb = '{0, 0, 0, 1, 1, 0, 0, 0};
        ec = '{0, 0, 1, 1, 1, 1, 0, 0};
        req[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            req[0] = 1'b0;
            check($sformatf("t1_a_edge%0d", e + 1), 32'(snap_pos[0]), 32'(ea[e]));
            check($sformatf("t1_b_neg%0d", e + 1), 32'(snap_neg[1]), 32'(eb[e]));
            check($sformatf("t1_c_edge%0d", e + 1), 32'(snap_pos[2]), 32'(ec[e]));
            if (e == 3) check("t1_b_halfcycle", 32'(snap_pos[1]), 32'h0);
        end
`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
        check("t1_scnt_a", 32'(scnt[0]), 32'd1);
        check("t1_scnt_c", 32'(scnt[2]), 32'd1);
`endif

        // Ten-cycle request on lane 2: width follows the input.
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        req[2] = 1'b1;
        for (int e = 0; e < 18; e++) begin
            step();
            if (e == 9) req[2] = 1'b0;
            cnt_a += int'(snap_pos[0][2]);
            cnt_b += int'(snap_neg[1][2]);
            cnt_c += int'(snap_pos[2][2]);
        end
        check("t2_width_a", 32'(cnt_a), 32'd10);
        check("t2_width_b", 32'(cnt_b), 32'd10);
        check("t2_width_c", 32'(cnt_c), 32'd10);
`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
        check("t2_scnt_c", 32'(scnt[2]), 32'd1);
`endif

        // Masked lane 1 stays silent; mask raised after the pulse starts does not cut it.
        cnt_a = 0; cnt_c = 0;
        mask[1] = 1'b1; req[1] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 4) req[1] = 1'b0;
            cnt_a += int'(snap_pos[0][1]);
        end
        check("t3_masked_a", 32'(cnt_a), 32'd0);
        mask[1] = 1'b0; req[1] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            req[1] = 1'b0;
            if (e == 2) mask[1] = 1'b1;
            cnt_a += int'(snap_pos[0][1]);
            cnt_c += int'(snap_pos[2][1]);
        end
        mask[1] = 1'b0;
        check("t3_full_a", 32'(cnt_a), 32'd2);
        check("t3_full_c", 32'(cnt_c), 32'd4);

        // Reset mid-pulse on lane 3, request held through release.
        req[3] = 1'b1;
        idle(4);
        check("t4_pre_a", 32'(snap_pos[0][3]), 32'h1);
        #2 RESET = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("t4_rst_sync_d%0d", d), 32'(sync_o[d]), 32'h0);
            check($sformatf("t4_rst_act_d%0d", d), 32'(act_o[d]), 32'h0);
            check($sformatf("t4_rst_scnt_d%0d", d), 32'(scnt[d]), 32'h0);
        end
        model_clear();
        step();
        RESET = 1'b0;
        ea = '{0, 0, 1, 1, 1, 1, 1, 1};
        for (int e = 0; e < 4; e++) begin
            step();
            check($sformatf("t4_rel_a_edge%0d", e + 1), 32'(snap_pos[0][3]), 32'(ea[e]));
        end
        req[3] = 1'b0;
        idle(8);

`ifdef LANECTRL_PAUSE_STRETCH_CNT_EN
        // Saturation, then clear coinciding with a stretch exit.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int p = 0; p < 300; p++) begin
            req[0] = 1'b1;
            step();
            req[0] = 1'b0;
            idle(5);
        end
        check("t5_sat_a", 32'(scnt[0]), 32'd255);
        check("t5_sat_b", 32'(scnt[1]), 32'd255);
        check("t5_sat_c", 32'(scnt[2]), 32'd255);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        idle(3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t5_clr_a", 32'(scnt[0]), 32'd0);
        idle(6);
`endif

        // Randomised traffic with occasional masks, clears and resets.
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(3) == 0) req[l] = ~req[l];
                mask[l] = ($urandom_range(7) == 0);
            end
            clr = ($urandom_range(63) == 0);
            if ($urandom_range(399) == 0) begin
                RESET = 1'b1;
                model_clear();
                step();
                RESET = 1'b0;
            end else begin
                step();
            end
        end
        req = '0; mask = '0; clr = 1'b0;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
